sequence_acquisition_seq: RTL and testbench
===========================================

Name: sequence_acquisition_seq

Overview:
- Parametrised successor to the 4-slot azmux/precharge sequencer; drives the azmux, the precharge switches and the ADC reset line in the minimal acquisition project.
- Sequence depth is configurable up to SEQ_MAX slots.
- Separate hold counts for each phase: boot, azmux settle, precharge settle.
- Free-running or one-shot (triggered) modes.
- Per-sample valid strobe and end-of-sequence strobe for the register/MCU readback path.

Parameters:
- SEQ_MAX, 8, maximum number of sequence slots (power of 2, at least 2).
- IDX_W, 3, log2(SEQ_MAX); width of the slot index.
- AZ_W, 4, azmux field width per slot.
- PC_W, 2, precharge-switch field width per slot.
- CNT_W, 24, width of the phase hold counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- p_seq_i  in  SEQ_MAX*(AZ_W+PC_W)  slot table. Slot k occupies [k*(AZ_W+PC_W) +: AZ_W+PC_W]; within a slot, azmux = [0 +: AZ_W] and pc = [AZ_W +: PC_W].
- p_seq_n_i  in  IDX_W+1  number of active slots.
- p_clk_count_boot_i  in  CNT_W  boot (pc=0) hold count.
- p_clk_count_azmux_i  in  CNT_W  azmux settle count.
- p_clk_count_pc_i  in  CNT_W  precharge settle count.
- p_oneshot_i  in  1  0 = free-run, 1 = one sequence per trigger.
- p_trig_i  in  1  one-shot start pulse.
- adc_measure_valid_i  in  1  ADC conversion complete.
- adc_reset_no  out  1  ADC held in reset when 0.
- pc_sw_o  out  PC_W  precharge switch drive.
- azmux_o  out  AZ_W  azmux drive.
- sample_idx_last_o  out  IDX_W  slot index of the last completed sample.
- sample_valid_o  out  1  1-cycle strobe when sample_idx_last_o updates.
- seq_done_o  out  1  1-cycle strobe on completion of the last slot.
- busy_o  out  1  high in every state except IDLE.
- monitor_o  out  8  combinational debug: [3:0] = 4 LSBs of the slot index, [4] = pc_sw_o[0], [5] = pc_sw_o[1], [6] = adc_reset_no, [7] = adc_measure_valid_i.

Behaviour:
- Reset values (every cycle reset=1):
  - state = IDLE, idx = 0, adc_reset_no = 0, pc_sw_o = 0.
  - azmux_o = slot0 azmux field.
  - sample_idx_last_o = all ones. This value is valid only when it cannot be confused with an active slot.
  - sample_valid_o = 0, seq_done_o = 0.
- Effective slot count N = clamp(p_seq_n_i, 1, SEQ_MAX). The value 0 is treated as 1.
- Phase timing: entering a hold phase loads the down-counter with count C. The phase exits on the cycle the counter reads 0, so the hold lasts C+1 cycles. C=0 is legal and gives a 1-cycle hold.
- IDLE:
  - Drives pc_sw_o = 0 and adc_reset_no = 0.
  - Exits to BOOT when p_oneshot_i = 0, or when p_oneshot_i = 1 and p_trig_i = 1.
  - p_trig_i is ignored in every other state.
- BOOT: pc_sw_o <= 0; load the boot count; hold -> AZ.
- AZ: azmux_o <= slot[idx] azmux field; load the azmux count; hold -> PC.
- PC: pc_sw_o <= slot[idx] pc field; load the pc count; hold -> MEASURE. On hold expiry, adc_reset_no <= 1.
- MEASURE: waits indefinitely for adc_measure_valid_i = 1. On that cycle:
  - adc_reset_no <= 0, sample_idx_last_o <= idx, sample_valid_o <= 1.
  - Next idx = (idx >= N-1) ? 0 : idx+1. Use >=, so a mid-run reduction of p_seq_n_i wraps cleanly.
  - On wrap, seq_done_o <= 1. Then go to IDLE if p_oneshot_i = 1, else to BOOT.
  - Without a wrap, go to BOOT.
- adc_measure_valid_i outside MEASURE is ignored.
- Table and count inputs are sampled at the cycle they are used. Software may rewrite them live; the change takes effect at the next use.
- Reset asserted mid-operation overrides all state updates in that cycle. No strobe is emitted.

Optional Feature:
- Macro: SEQ_ACQ_TIMEOUT_EN.
- When defined:
  - Adds input p_clk_count_timeout_i [CNT_W] and output timeout_o (sticky error flag).
  - In MEASURE, a second counter loaded with p_clk_count_timeout_i on entry runs down. If it reaches 0 before valid, the block sets adc_reset_no = 0 and timeout_o = 1, emits no sample_valid_o, and goes to BOOT with idx unchanged (retry the same slot).
  - timeout_o is cleared only by reset.
- When not defined: MEASURE waits forever; neither port exists.

Test Plan:
- Free-run, N=2, boot=2, azmux=3, pc=4, slots {az=3,pc=1},{az=7,pc=2}, ADC valid 10 cycles after adc_reset_no rises -> azmux_o 3,7,3,7…; pc_sw_o 0→1 and 0→2. Phase holds are exactly 3/4/5 cycles. sample_idx_last_o 0,1,0…; seq_done_o pulses after each idx=1 sample.
- p_seq_n_i=0 and p_seq_n_i=15 (SEQ_MAX=8) -> N=1 gives idx always 0 with seq_done_o on every sample; N=8 cycles idx 0..7.
- One-shot, N=3, no trigger for 50 cycles -> busy_o=0, adc_reset_no=0. Pulse p_trig_i -> exactly 3 sample_valid_o, 1 seq_done_o, then IDLE. A trigger pulsed while busy is ignored.
- p_seq_n_i changed from 4 to 2 while idx=3 in MEASURE -> after valid, idx wraps to 0 and seq_done_o pulses.
- Reset asserted in MEASURE with adc_reset_no=1 -> next cycle adc_reset_no=0, pc_sw_o=0, sample_idx_last_o=7, no strobes. Deassert -> restarts from slot 0.
- With SEQ_ACQ_TIMEOUT_EN, timeout=20, ADC never valid -> after 21 MEASURE cycles timeout_o=1, no sample_valid_o, same slot retried.

Source files
------------

// File: rtl/sequence_acquisition_seq.sv
// Acquisition sequencer: steps through a table of azmux/precharge slots, holding each
// phase for a programmable count, then waits for the ADC to report a conversion.
// Optional build macro SEQ_ACQ_TIMEOUT_EN adds a MEASURE watchdog that retries the slot
// and sets a sticky timeout_o flag.
module sequence_acquisition_seq #(
   parameter int unsigned SEQ_MAX = 8,
   parameter int unsigned IDX_W   = 3,
   parameter int unsigned AZ_W    = 4,
   parameter int unsigned PC_W    = 2,
   parameter int unsigned CNT_W   = 24
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [SEQ_MAX*(AZ_W+PC_W)-1:0] p_seq_i,
   input  logic [IDX_W:0]                 p_seq_n_i,
   input  logic [CNT_W-1:0]               p_clk_count_boot_i,
   input  logic [CNT_W-1:0]               p_clk_count_azmux_i,
   input  logic [CNT_W-1:0]               p_clk_count_pc_i,
`ifdef SEQ_ACQ_TIMEOUT_EN
   input  logic [CNT_W-1:0]               p_clk_count_timeout_i,
   output logic                           timeout_o,
`endif
   input  logic                           p_oneshot_i,
   input  logic                           p_trig_i,
   input  logic                           adc_measure_valid_i,
   output logic                           adc_reset_no,
   output logic [PC_W-1:0]                pc_sw_o,
   output logic [AZ_W-1:0]                azmux_o,
   output logic [IDX_W-1:0]               sample_idx_last_o,
   output logic                           sample_valid_o,
   output logic                           seq_done_o,
   output logic                           busy_o,
   output logic [7:0]                     monitor_o
);

   localparam int unsigned SlotW = AZ_W + PC_W;
   localparam logic [IDX_W:0] NMax = (IDX_W + 1)'(SEQ_MAX);
   localparam logic [IDX_W:0] NOne = (IDX_W + 1)'(1);

   typedef enum logic [2:0] {StIdle, StBoot, StAz, StPc, StMeasure} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               adc_rst_n_q, adc_rst_n_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [AZ_W-1:0]    az_q, az_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
`ifdef SEQ_ACQ_TIMEOUT_EN
   logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic               tmo_q, tmo_d;
`endif

   logic [SlotW-1:0]   slots [SEQ_MAX];
   logic [SlotW-1:0]   cur_slot;
   logic [IDX_W:0]     n_eff;
   logic               wrap;
   logic               cnt_zero;
   logic [31:0]        idx_ext;

   // Unpack the flat slot table into an indexable array.
   for (genvar k = 0; k < SEQ_MAX; k++) begin : g_slot
      assign slots[k] = p_seq_i[k*SlotW +: SlotW];
   end

   assign cur_slot = slots[idx_q];
   assign cnt_zero = (cnt_q == '0);

   // Clamp the active slot count to 1..SEQ_MAX; >= lets a live shrink wrap cleanly.
   always_comb begin
      if (p_seq_n_i == '0) begin
         n_eff = NOne;
      end else if (p_seq_n_i > NMax) begin
         n_eff = NMax;
      end else begin
         n_eff = p_seq_n_i;
      end
      wrap = ({1'b0, idx_q} >= (n_eff - NOne));
   end

   // Next-state and registered-output logic; hold phases exit when the counter reads 0.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      adc_rst_n_d = adc_rst_n_q;
      pc_d        = pc_q;
      az_d        = az_q;
      last_d      = last_q;
      valid_d     = 1'b0;
      done_d      = 1'b0;
`ifdef SEQ_ACQ_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      tmo_d       = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            pc_d        = '0;
            adc_rst_n_d = 1'b0;
            if (!p_oneshot_i || p_trig_i) begin
               state_d = StBoot;
               cnt_d   = p_clk_count_boot_i;
            end
         end
         StBoot: begin
            pc_d = '0;
            if (cnt_zero) begin
               state_d = StAz;
               az_d    = cur_slot[0 +: AZ_W];
               cnt_d   = p_clk_count_azmux_i;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StAz: begin
            if (cnt_zero) begin
               state_d = StPc;
               pc_d    = cur_slot[AZ_W +: PC_W];
               cnt_d   = p_clk_count_pc_i;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StPc: begin
            if (cnt_zero) begin
               state_d     = StMeasure;
               adc_rst_n_d = 1'b1;
`ifdef SEQ_ACQ_TIMEOUT_EN
               tmo_cnt_d   = p_clk_count_timeout_i;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StMeasure: begin
            if (adc_measure_valid_i) begin
               adc_rst_n_d = 1'b0;
               last_d      = idx_q;
               valid_d     = 1'b1;
               if (wrap) begin
                  idx_d  = '0;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               if (wrap && p_oneshot_i) begin
                  state_d = StIdle;
                  pc_d    = '0;
               end else begin
                  state_d = StBoot;
                  pc_d    = '0;
                  cnt_d   = p_clk_count_boot_i;
               end
`ifdef SEQ_ACQ_TIMEOUT_EN
            end else if (tmo_cnt_q == '0) begin
               // ADC never answered: drop it back into reset and retry the same slot.
               adc_rst_n_d = 1'b0;
               tmo_d       = 1'b1;
               state_d     = StBoot;
               pc_d        = '0;
               cnt_d       = p_clk_count_boot_i;
            end else begin
               tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
`endif
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         adc_rst_n_q <= 1'b0;
         pc_q        <= '0;
         az_q        <= slots[0][0 +: AZ_W];
         last_q      <= '1;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
`ifdef SEQ_ACQ_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         tmo_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         adc_rst_n_q <= adc_rst_n_d;
         pc_q        <= pc_d;
         az_q        <= az_d;
         last_q      <= last_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
`ifdef SEQ_ACQ_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign idx_ext = 32'(idx_q);

   assign adc_reset_no      = adc_rst_n_q;
   assign pc_sw_o           = pc_q;
   assign azmux_o           = az_q;
   assign sample_idx_last_o = last_q;
   assign sample_valid_o    = valid_q;
   assign seq_done_o        = done_q;
   assign busy_o            = (state_q != StIdle);
   assign monitor_o         = {adc_measure_valid_i, adc_rst_n_q, pc_q[1], pc_q[0], idx_ext[3:0]};
`ifdef SEQ_ACQ_TIMEOUT_EN
   assign timeout_o         = tmo_q;
`endif

endmodule

// File: tb/tb_sequence_acquisition_seq.sv
// Directed bench for sequence_acquisition_seq: table of per-sample expectations plus
// hand-written one-shot, mid-run reset and (with SEQ_ACQ_TIMEOUT_EN) timeout sequences.
module tb_sequence_acquisition_seq;

   localparam int BootC = 2;
   localparam int AzC   = 3;
   localparam int PcC   = 4;

   typedef struct {
      int n;       // p_seq_n_i applied while in MEASURE, just before valid
      int az;
      int pc;
      int idx;
      int done;
      int chk_az;  // azmux changes in this slot, so its timing is observable
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [47:0] p_seq;
   logic [3:0]  p_seq_n;
   logic [23:0] cnt_boot, cnt_az, cnt_pc;
   logic        oneshot, trig, valid_in;
   logic        adc_reset_no;
   logic [1:0]  pc_sw;
   logic [3:0]  azmux;
   logic [2:0]  idx_last;
   logic        sample_valid, seq_done, busy;
   logic [7:0]  monitor;
`ifdef SEQ_ACQ_TIMEOUT_EN
   logic [23:0] cnt_tmo;
   logic        timeout;
`endif

   int total = 0;
   int bad   = 0;
   int n_sv  = 0;
   int n_done = 0;
   vec_t tbl [19];
   vec_t osv [3];

   always #5 clk = ~clk;

   sequence_acquisition_seq dut (
      .clk                   (clk),
      .reset                 (reset),
      .p_seq_i               (p_seq),
      .p_seq_n_i             (p_seq_n),
      .p_clk_count_boot_i    (cnt_boot),
      .p_clk_count_azmux_i   (cnt_az),
      .p_clk_count_pc_i      (cnt_pc),
`ifdef SEQ_ACQ_TIMEOUT_EN
      .p_clk_count_timeout_i (cnt_tmo),
      .timeout_o             (timeout),
`endif
      .p_oneshot_i           (oneshot),
      .p_trig_i              (trig),
      .adc_measure_valid_i   (valid_in),
      .adc_reset_no          (adc_reset_no),
      .pc_sw_o               (pc_sw),
      .azmux_o               (azmux),
      .sample_idx_last_o     (idx_last),
      .sample_valid_o        (sample_valid),
      .seq_done_o            (seq_done),
      .busy_o                (busy),
      .monitor_o             (monitor)
   );

   // Strobe counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (sample_valid) n_sv <= n_sv + 1;
      if (seq_done) n_done <= n_done + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entered at negedge j0 (j=1 is the first negedge after the sequence starts at BOOT).
   // Checks phase timing, drives the ADC valid 10 cycles after adc_reset_no rises and checks
   // the strobes; returns at j=1 of the following slot.
   task automatic run_slot(input vec_t v, input int j0);
      int j;
      int t_az;
      int t_pc;
      int t_adc;
      j = j0; t_az = -1; t_pc = -1; t_adc = -1;
      while (j <= 200) begin
         if (t_az < 0 && azmux == 4'(v.az)) t_az = j;
         if (t_pc < 0 && pc_sw != 2'd0) t_pc = j;
         if (adc_reset_no) begin
            t_adc = j;
            break;
         end
         @(negedge clk);
         j++;
      end
      if (v.chk_az != 0) check("az_time", t_az, BootC + 2);
      check("pc_time", t_pc, BootC + AzC + 3);
      check("adc_time", t_adc, BootC + AzC + PcC + 4);
      check("azmux", int'(azmux), v.az);
      check("pc_sw", int'(pc_sw), v.pc);
      check("monitor", int'(monitor), 64 + v.pc * 16 + v.idx);
      repeat (10) @(negedge clk);
      check("adc_held", int'(adc_reset_no), 1);
      check("no_early_valid", int'(sample_valid), 0);
      p_seq_n  = 4'(v.n);
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      check("sample_valid", int'(sample_valid), 1);
      check("idx_last", int'(idx_last), v.idx);
      check("seq_done", int'(seq_done), v.done);
      check("adc_low_after", int'(adc_reset_no), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int az_t [8];
      int pc_t [8];
      int idle_bad;
      int sv0;
      int dn0;
      int c;
      az_t = '{3, 7, 9, 10, 11, 12, 13, 14};
      pc_t = '{1, 2, 3, 1, 2, 3, 1, 2};
      for (int k = 0; k < 8; k++) p_seq[k*6 +: 6] = {2'(pc_t[k]), 4'(az_t[k])};

      tbl[0]  = '{2, 3, 1, 0, 0, 0};
      tbl[1]  = '{2, 7, 2, 1, 1, 1};
      tbl[2]  = '{2, 3, 1, 0, 0, 1};
      tbl[3]  = '{2, 7, 2, 1, 1, 1};
      tbl[4]  = '{0, 3, 1, 0, 1, 1};
      tbl[5]  = '{0, 3, 1, 0, 1, 0};
      tbl[6]  = '{15, 3, 1, 0, 0, 0};
      tbl[7]  = '{15, 7, 2, 1, 0, 1};
      tbl[8]  = '{15, 9, 3, 2, 0, 1};
      tbl[9]  = '{15, 10, 1, 3, 0, 1};
      tbl[10] = '{15, 11, 2, 4, 0, 1};
      tbl[11] = '{15, 12, 3, 5, 0, 1};
      tbl[12] = '{15, 13, 1, 6, 0, 1};
      tbl[13] = '{15, 14, 2, 7, 1, 1};
      tbl[14] = '{4, 3, 1, 0, 0, 1};
      tbl[15] = '{4, 7, 2, 1, 0, 1};
      tbl[16] = '{4, 9, 3, 2, 0, 1};
      tbl[17] = '{2, 10, 1, 3, 1, 1};  // count shrinks 4 -> 2 while idx=3 waits
      tbl[18] = '{2, 3, 1, 0, 0, 1};
      osv[0]  = '{3, 3, 1, 0, 0, 0};
      osv[1]  = '{3, 7, 2, 1, 0, 1};
      osv[2]  = '{3, 9, 3, 2, 1, 1};

      reset = 1'b1; p_seq_n = 4'd2; oneshot = 1'b0; trig = 1'b0; valid_in = 1'b0;
      cnt_boot = 24'(BootC); cnt_az = 24'(AzC); cnt_pc = 24'(PcC);
`ifdef SEQ_ACQ_TIMEOUT_EN
      cnt_tmo = 24'd20;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_adc", int'(adc_reset_no), 0);
      check("rst_pc", int'(pc_sw), 0);
      check("rst_az", int'(azmux), 3);
      check("rst_idx_last", int'(idx_last), 7);
      check("rst_valid", int'(sample_valid), 0);
      check("rst_done", int'(seq_done), 0);
      check("rst_monitor", int'(monitor), 0);
`ifdef SEQ_ACQ_TIMEOUT_EN
      check("rst_timeout", int'(timeout), 0);
`endif

      // Free-run table.
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 19; i++) run_slot(tbl[i], 1);

      // One-shot: stays idle without a trigger, then exactly one sequence.
      reset = 1'b1; oneshot = 1'b1; p_seq_n = 4'd3;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy || adc_reset_no) idle_bad++;
      end
      check("oneshot_idle", idle_bad, 0);
      sv0 = n_sv; dn0 = n_done;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      check("oneshot_started", int'(busy), 1);
      run_slot(osv[0], 1);
      trig = 1'b1;  // ignored while busy
      @(negedge clk);
      trig = 1'b0;
      run_slot(osv[1], 2);
      run_slot(osv[2], 1);
      check("oneshot_back_idle", int'(busy), 0);
      check("oneshot_pc_off", int'(pc_sw), 0);
      idle_bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy || adc_reset_no) idle_bad++;
      end
      check("oneshot_stay_idle", idle_bad, 0);
      check("oneshot_valid_count", n_sv - sv0, 3);
      check("oneshot_done_count", n_done - dn0, 1);

      // Reset while waiting in MEASURE; a coincident ADC valid must not strobe.
      oneshot = 1'b0; p_seq_n = 4'd2;
      c = 0;
      while (!adc_reset_no && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("reach_measure", int'(adc_reset_no), 1);
      reset = 1'b1; valid_in = 1'b1;
      @(negedge clk);
      check("mid_rst_adc", int'(adc_reset_no), 0);
      check("mid_rst_pc", int'(pc_sw), 0);
      check("mid_rst_idx_last", int'(idx_last), 7);
      check("mid_rst_valid", int'(sample_valid), 0);
      check("mid_rst_done", int'(seq_done), 0);
      reset = 1'b0; valid_in = 1'b0;
      @(negedge clk);
      run_slot(tbl[0], 1);

`ifdef SEQ_ACQ_TIMEOUT_EN
      // ADC never answers on slot 1: 21 MEASURE cycles, then retry the same slot.
      sv0 = n_sv;
      c = 0;
      while (!adc_reset_no && c < 100) begin
         @(negedge clk);
         c++;
      end
      c = 0;
      while (adc_reset_no && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("tmo_measure_cycles", c, 21);
      check("tmo_flag", int'(timeout), 1);
      check("tmo_no_valid", n_sv - sv0, 0);
      run_slot('{2, 7, 2, 1, 1, 0}, 1);
      check("tmo_sticky", int'(timeout), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
